// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_t;

  localparam int MEM_LAT_DEFAULT       = 1;
  localparam int DMA_BURST_MAX_DEFAULT = 4;

  // Streak counter width; never narrower than one bit so a strict-priority
  // build (burst max of 0) still has a legal vector.
  function automatic int streak_width(input int burst_max);
    return (burst_max > 0) ? $clog2(burst_max + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between CPU and DMA for the next memory access.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEFAULT,
  parameter int SW            = streak_width(DMA_BURST_MAX)
) (
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic [SW-1:0] streak,
  output logic          win_vld,
  output logic          win_dma
);

  logic under_limit;

  // DMA takes ties until it has used up its burst allowance against a waiting CPU
  always_comb begin
    under_limit = (streak < SW'(DMA_BURST_MAX));
    win_vld     = cpu_req | dma_req;
    win_dma     = dma_req & (~cpu_req | under_limit);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU path and the DMA data-break channel.
// Latency: grant 1 cycle after req is sampled; read data MEM_LAT+1 cycles after that.
// Backpressure: requests are only sampled in IDLE/RESP; a requester holds req until its gnt.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT       = MEM_LAT_DEFAULT,
  parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEFAULT
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [11:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [11:0] dma_addr,
  input  logic [11:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [11:0] dma_rdata,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [11:0] mem_read_data,
  output logic        busy
);

  localparam int SW = streak_width(DMA_BURST_MAX);

  arb_state_t    state, state_nxt;
  arb_owner_t    owner;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] streak;

  logic          win_vld, win_dma;
  logic          take, rd_done;
  logic          win_we;
  logic [11:0]   win_addr, win_wdata;

  logic          cpu_gnt_nxt, dma_gnt_nxt;
  logic          cpu_rvalid_nxt, dma_rvalid_nxt;
  logic [11:0]   cpu_rdata_nxt, dma_rdata_nxt;
  logic [11:0]   mem_address_nxt, mem_write_data_nxt;
  logic          mem_write_enable_nxt, mem_read_enable_nxt;
  logic          busy_nxt;

  mem_arb_pick #(
    .DMA_BURST_MAX (DMA_BURST_MAX),
    .SW            (SW)
  ) u_pick (
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .streak  (streak),
    .win_vld (win_vld),
    .win_dma (win_dma)
  );

  // Arbitration happens only at the edge that ends IDLE or RESP
  always_comb begin
    take      = ((state == IDLE) || (state == RESP)) && win_vld;
    rd_done   = (state == WAIT) && (lat_cnt == 3'd1);
    win_we    = win_dma ? dma_we    : cpu_we;
    win_addr  = win_dma ? dma_addr  : cpu_addr;
    win_wdata = win_dma ? dma_wdata : cpu_wdata;
  end

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: writes finish after ISSUE, reads wait out the memory latency
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RESP: state_nxt = win_vld ? ISSUE : IDLE;
      ISSUE:      state_nxt = mem_write_enable ? IDLE : WAIT;
      WAIT:       state_nxt = rd_done ? RESP : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next output values; strobes and grants default low, buses hold
  always_comb begin
    cpu_gnt_nxt          = 1'b0;
    dma_gnt_nxt          = 1'b0;
    cpu_rvalid_nxt       = 1'b0;
    dma_rvalid_nxt       = 1'b0;
    cpu_rdata_nxt        = cpu_rdata;
    dma_rdata_nxt        = dma_rdata;
    mem_address_nxt      = mem_address;
    mem_write_data_nxt   = mem_write_data;
    mem_write_enable_nxt = 1'b0;
    mem_read_enable_nxt  = 1'b0;
    busy_nxt             = (state_nxt != IDLE);
    if (take) begin
      mem_address_nxt      = win_addr;
      mem_write_data_nxt   = win_wdata;
      mem_write_enable_nxt = win_we;
      mem_read_enable_nxt  = ~win_we;
      cpu_gnt_nxt          = ~win_dma;
      dma_gnt_nxt          = win_dma;
    end
    if (rd_done) begin
      if (owner == OWN_DMA) begin
        dma_rvalid_nxt = 1'b1;
        dma_rdata_nxt  = mem_read_data;
      end else begin
        cpu_rvalid_nxt = 1'b1;
        cpu_rdata_nxt  = mem_read_data;
      end
    end
  end

  // Output registers; reset clears every output at once, abandoning any access
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cpu_gnt          <= 1'b0;
      dma_gnt          <= 1'b0;
      cpu_rvalid       <= 1'b0;
      dma_rvalid       <= 1'b0;
      cpu_rdata        <= '0;
      dma_rdata        <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      busy             <= 1'b0;
    end else begin
      cpu_gnt          <= cpu_gnt_nxt;
      dma_gnt          <= dma_gnt_nxt;
      cpu_rvalid       <= cpu_rvalid_nxt;
      dma_rvalid       <= dma_rvalid_nxt;
      cpu_rdata        <= cpu_rdata_nxt;
      dma_rdata        <= dma_rdata_nxt;
      mem_address      <= mem_address_nxt;
      mem_write_data   <= mem_write_data_nxt;
      mem_write_enable <= mem_write_enable_nxt;
      mem_read_enable  <= mem_read_enable_nxt;
      busy             <= busy_nxt;
    end
  end

  // Owner, read-latency countdown and DMA streak against a waiting CPU
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      owner   <= OWN_CPU;
      lat_cnt <= '0;
      streak  <= '0;
    end else begin
      if (take) begin
        owner <= win_dma ? OWN_DMA : OWN_CPU;
        if (win_dma && cpu_req) begin
          if (streak != SW'(DMA_BURST_MAX)) streak <= streak + SW'(1);
        end else begin
          streak <= '0;
        end
      end
      if ((state == ISSUE) && mem_read_enable) lat_cnt <= 3'(MEM_LAT);
      else if (state == WAIT)                  lat_cnt <= lat_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dut0 (MEM_LAT=1, burst 4), dut1 (MEM_LAT=3, burst 0).
// Stimulus pushes expected grant/read events; a negedge monitor pops and compares them.
// Each requester drops req on seeing its grant, except in the held-request streak test.
module tb_mem_port_arbiter;

  typedef struct {
    bit          rv;
    bit          dm;
    logic [11:0] d;
    int          cyc;
  } exp_t;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        cpu_req [2], cpu_we [2], dma_req [2], dma_we [2];
  logic [11:0] cpu_addr [2], cpu_wdata [2], dma_addr [2], dma_wdata [2];
  logic        cpu_gnt [2], cpu_rvalid [2], dma_gnt [2], dma_rvalid [2];
  logic        mem_we [2], mem_re [2], busy [2];
  logic [11:0] cpu_rdata [2], dma_rdata [2], mem_addr [2], mem_wd [2], mem_rd [2];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   gnt_seen [2];
  exp_t q0 [$];
  exp_t q1 [$];

  logic [11:0] mem [2][4096];
  bit          wr [2][4096];
  int          cd [2];
  logic [11:0] la [2];

  mem_port_arbiter #(.MEM_LAT(LAT0), .DMA_BURST_MAX(4)) dut0 (
    .clock(clock), .resetN(resetN),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
    .dma_gnt(dma_gnt[0]), .dma_rvalid(dma_rvalid[0]), .dma_rdata(dma_rdata[0]),
    .mem_address(mem_addr[0]), .mem_write_data(mem_wd[0]), .mem_write_enable(mem_we[0]),
    .mem_read_enable(mem_re[0]), .mem_read_data(mem_rd[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.MEM_LAT(LAT1), .DMA_BURST_MAX(0)) dut1 (
    .clock(clock), .resetN(resetN),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
    .dma_gnt(dma_gnt[1]), .dma_rvalid(dma_rvalid[1]), .dma_rdata(dma_rdata[1]),
    .mem_address(mem_addr[1]), .mem_write_data(mem_wd[1]), .mem_write_enable(mem_we[1]),
    .mem_read_enable(mem_re[1]), .mem_read_data(mem_rd[1]), .busy(busy[1])
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [11:0] init_val(input logic [11:0] a);
    case (a)
      12'o7777: return 12'o4321;
      12'o0200: return 12'o0765;
      default:  return 12'o0000;
    endcase
  endfunction

  // Memory model: data valid only in the cycle MEM_LAT after the read strobe
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_we[i]) begin
        mem[i][mem_addr[i]] <= mem_wd[i];
        wr[i][mem_addr[i]]  <= 1'b1;
      end
      if (mem_re[i]) begin
        cd[i] <= (i == 0) ? LAT0 : LAT1;
        la[i] <= mem_addr[i];
      end else if (cd[i] != 0) begin
        cd[i] <= cd[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rd[i] = (cd[i] == 1) ? (wr[i][la[i]] ? mem[i][la[i]] : init_val(la[i])) : 12'o5555;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'o%0o required 'o%0o (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input bit rv, input bit dm, input logic [11:0] d, input int c);
    exp_t e;
    e.rv = rv; e.dm = dm; e.d = d; e.cyc = c;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic got(input int i, input bit rv, input bit dm, input logic [11:0] d);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      chk($sformatf("unexpected_evt_dut%0d_rv%0d_dma%0d", i, rv, dm), 0, 1);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("evt_kind_dut%0d", i), int'({rv, dm}), int'({e.rv, e.dm}));
    if (e.cyc >= 0) chk($sformatf("evt_cycle_dut%0d", i), cyc, e.cyc);
    if (e.rv) chk($sformatf("evt_rdata_dut%0d", i), int'(d), int'(e.d));
  endtask

  // Monitor: every grant or read-valid the DUTs present is matched against the queue
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (cpu_gnt[i])    begin gnt_seen[i]++; got(i, 1'b0, 1'b0, 12'o0); end
      if (dma_gnt[i])    begin gnt_seen[i]++; got(i, 1'b0, 1'b1, 12'o0); end
      if (cpu_rvalid[i]) got(i, 1'b1, 1'b0, cpu_rdata[i]);
      if (dma_rvalid[i]) got(i, 1'b1, 1'b1, dma_rdata[i]);
    end
  end

  task automatic wait_sig(input int i, input int which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      case (which)
        0:       seen = cpu_gnt[i];
        1:       seen = dma_gnt[i];
        2:       seen = cpu_rvalid[i];
        3:       seen = dma_rvalid[i];
        default: seen = ~busy[i];
      endcase
    end
    if (!seen) chk({"timeout_", nm}, 0, 1);
  endtask

  task automatic chk_zero(input int i, input string nm);
    chk(nm, int'({cpu_gnt[i], cpu_rvalid[i], dma_gnt[i], dma_rvalid[i], mem_we[i], mem_re[i], busy[i]}), 0);
    chk({nm, "_bus"}, int'(cpu_rdata[i] | dma_rdata[i] | mem_addr[i] | mem_wd[i]), 0);
  endtask

  task automatic cpu_go(input int i, input logic we, input logic [11:0] a, input logic [11:0] wd, output int n);
    @(posedge clock); #1;
    cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = wd;
    n = cyc;
  endtask

  task automatic dma_go(input int i, input logic we, input logic [11:0] a, input logic [11:0] wd, output int n);
    @(posedge clock); #1;
    dma_req[i] = 1'b1; dma_we[i] = we; dma_addr[i] = a; dma_wdata[i] = wd;
    n = cyc;
  endtask

  initial begin
    int n, m, rd_cnt, busy_cnt;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      dma_req[i] = 1'b0; dma_we[i] = 1'b0; dma_addr[i] = '0; dma_wdata[i] = '0;
    end
    resetN = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero(0, "reset_dut0");
    chk_zero(1, "reset_dut1");
    @(posedge clock); #1 resetN = 1'b1;

    // Reset in the middle of a read: outputs clear at once, no read-valid follows
    cpu_go(0, 1'b0, 12'o0200, 12'o0, n);
    push(0, 1'b0, 1'b0, 12'o0, n + 1);
    wait_sig(0, 0, "t1_gnt");
    cpu_req[0] = 1'b0;
    @(negedge clock);
    chk("t1_busy_in_wait", int'(busy[0]), 1);
    resetN = 1'b0;
    #1;
    chk_zero(0, "t1_async_reset");
    @(posedge clock); #1 resetN = 1'b1;
    cpu_go(0, 1'b0, 12'o0200, 12'o0, n);
    push(0, 1'b0, 1'b0, 12'o0, n + 1);
    push(0, 1'b1, 1'b0, 12'o0765, n + 3);
    wait_sig(0, 0, "t1b_gnt");
    cpu_req[0] = 1'b0;
    wait_sig(0, 2, "t1b_rv");

    // CPU write then read-back of the same word
    cpu_go(0, 1'b1, 12'o0020, 12'o1234, n);
    push(0, 1'b0, 1'b0, 12'o0, n + 1);
    wait_sig(0, 0, "t2w_gnt");
    cpu_req[0] = 1'b0;
    chk("t2_wen", int'(mem_we[0]), 1);
    chk("t2_ren", int'(mem_re[0]), 0);
    chk("t2_addr", int'(mem_addr[0]), int'(12'o0020));
    chk("t2_wdata", int'(mem_wd[0]), int'(12'o1234));
    cpu_go(0, 1'b0, 12'o0020, 12'o0, n);
    push(0, 1'b0, 1'b0, 12'o0, n + 1);
    push(0, 1'b1, 1'b0, 12'o1234, n + 3);
    wait_sig(0, 0, "t2r_gnt");
    cpu_req[0] = 1'b0;
    chk("t2_ren_issue", int'({mem_re[0], mem_we[0]}), 2);
    wait_sig(0, 2, "t2_rv");
    chk("t2_dma_rdata_idle", int'(dma_rdata[0]), 0);

    // DMA read while a CPU read waits; CPU is granted at the end of DMA RESP
    dma_go(0, 1'b0, 12'o7777, 12'o0, n);
    push(0, 1'b0, 1'b1, 12'o0, n + 1);
    push(0, 1'b1, 1'b1, 12'o4321, n + 3);
    push(0, 1'b0, 1'b0, 12'o0, n + 4);
    push(0, 1'b1, 1'b0, 12'o1234, n + 6);
    wait_sig(0, 1, "t5_dgnt");
    dma_req[0] = 1'b0;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 12'o0020;
    wait_sig(0, 3, "t5_drv");
    chk("t5_cpu_rdata_kept", int'(cpu_rdata[0]), int'(12'o1234));
    wait_sig(0, 0, "t5_cgnt");
    cpu_req[0] = 1'b0;
    wait_sig(0, 2, "t5_crv");

    // Both held for ten write grants: D,D,D,D,C repeating
    @(posedge clock); #1;
    n = cyc;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 12'o0040; cpu_wdata[0] = 12'o1111;
    dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 12'o0041; dma_wdata[0] = 12'o2222;
    for (int k = 0; k < 10; k++) push(0, 1'b0, (k % 5) != 4, 12'o0, n + 1 + 2 * k);
    m = gnt_seen[0];
    for (int k = 0; k < 80 && gnt_seen[0] < m + 10; k++) @(negedge clock);
    cpu_req[0] = 1'b0;
    dma_req[0] = 1'b0;
    chk("t3_grant_count", gnt_seen[0] - m, 10);
    wait_sig(0, 4, "t3_idle");

    // Strict CPU priority build: CPU first, DMA next
    @(posedge clock); #1;
    n = cyc;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b1; cpu_addr[1] = 12'o0100; cpu_wdata[1] = 12'o0123;
    dma_req[1] = 1'b1; dma_we[1] = 1'b1; dma_addr[1] = 12'o0101; dma_wdata[1] = 12'o0456;
    push(1, 1'b0, 1'b0, 12'o0, n + 1);
    push(1, 1'b0, 1'b1, 12'o0, n + 3);
    wait_sig(1, 0, "t4_cgnt");
    cpu_req[1] = 1'b0;
    wait_sig(1, 1, "t4_dgnt");
    dma_req[1] = 1'b0;

    // MEM_LAT=3 read: one read strobe, rvalid 4 cycles after grant, busy throughout
    cpu_go(1, 1'b0, 12'o0100, 12'o0, n);
    push(1, 1'b0, 1'b0, 12'o0, n + 1);
    push(1, 1'b1, 1'b0, 12'o0123, n + 5);
    rd_cnt = 0;
    busy_cnt = 0;
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) cpu_req[1] = 1'b0;
      rd_cnt   += int'(mem_re[1]);
      busy_cnt += int'(busy[1]);
    end
    chk("t6_read_strobe_cycles", rd_cnt, 1);
    chk("t6_busy_cycles", busy_cnt, 5);
    @(negedge clock);
    chk("t6_idle_after", int'(busy[1]), 0);
    chk("t6_dma_rdata_untouched", int'(dma_rdata[1]), 0);

    repeat (4) @(negedge clock);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
